cpu_seq_ctrl: RTL and testbench
===============================

// Module: cpu_seq_ctrl
// PURPOSE
//  Multicycle sequencer for the 32-bit processor datapath (InstrFetch, RegFetch, Execute, DataMemory).
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes.
//  Handles waited data-memory/IO accesses (req/ack), a memory-wait timeout, and halt from a KEY.
//  Retires one instruction per pc_we pulse.
// PARAMETERS
//  OP_BIT_WIDTH   4    width of op1/op2 fields
//  WAIT_MAX       15   max cycles in MEM without mem_ack before bus error (1..255)
//  CNT_BITS       32   width of retired-instruction counter
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  op1        in   4   decoded primary opcode of the current IR
//  cond       in   1   Execute condition output (branch taken)
//  mem_ack    in   1   data memory/IO access complete (level, sampled in MEM)
//  halt_req   in   1   request to stop at next instruction boundary
//  step_req   in   1   single-step pulse (used only with CPU_SSTEP_EN)
//  ir_we      out  1   latch instruction word into IR
//  reg_we     out  1   register-file write enable
//  mem_req    out  1   data memory/IO access request
//  mem_we     out  1   data memory/IO write (qualifies mem_req)
//  pc_we      out  1   PC update; one pulse per retired instruction
//  pc_sel     out  2   00 PC+4, 01 branch target (imm32), 10 JAL target (outAlu)
//  wb_sel     out  2   00 outAlu, 01 outMem, 10 PC (JAL link)
//  state      out  3   FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
//  halted     out  1   1 while in HALT
//  bus_err    out  1   sticky: set on MEM timeout, cleared only by reset
//  illegal    out  1   one-cycle pulse on unknown op1 in EXEC
//  instr_cnt  out  32  retired-instruction count, wraps at 2^CNT_BITS
// BEHAVIOUR
//  Reset (async, reset_n=0): state=FETCH, all strobes 0, pc_sel=wb_sel=0, halted=0, bus_err=0, instr_cnt=0.
//  Strobes are combinational decodes of registered state + op1; no strobe outside the states listed.
//  FETCH: ir_we=1 -> DECODE. DECODE: no strobes -> EXEC.
//  EXEC, by op1:
//   ALUR 0000 / ALUI 1000 / CMPR 0010 / CMPI 1010 -> WB, wb_sel=00.
//   LW 1001 / SW 0101 -> MEM.  JAL 1011 -> WB, wb_sel=10, pc_sel=10.
//   BCOND 0110: pc_we=1, pc_sel = cond ? 01 : 00 -> boundary (retires in EXEC, 3 cycles).
//   any other: illegal=1, pc_we=1, pc_sel=00 -> boundary (treated as NOP).
//  MEM: mem_req=1, mem_we=(op1==SW); wait counter counts cycles in MEM from 1.
//   mem_ack=1: SW -> pc_we=1, pc_sel=00, boundary; LW -> WB, wb_sel=01. Counter cleared.
//   counter==WAIT_MAX and no ack: bus_err<=1 -> HALT, no pc_we, no reg_we; instruction not retired.
//   ack on the WAIT_MAX cycle itself wins over timeout.
//  WB: reg_we=1, pc_we=1, pc_sel=10 for JAL else 00 -> boundary.
//  Boundary: next state = HALT if halt_req=1 or bus_err=1, else FETCH.
//  HALT: all strobes 0, halted=1; halt_req=0 and bus_err=0 -> FETCH; stays in HALT forever once bus_err=1.
//  instr_cnt increments on every pc_we pulse, including illegal NOPs; wraps to 0.
//  halt_req asserted mid-instruction never aborts it; it is sampled only at the boundary.
//  Latency: ALU/CMP/JAL 4 cycles, BCOND 3, SW 4+waits, LW 5+waits (wait = cycles in MEM beyond 1).
// CONFIGURATION
//  CPU_SSTEP_EN defined: in HALT, step_req=1 (rising edge detected internally) runs exactly
//   one instruction from FETCH, then returns to HALT regardless of halt_req; ignored if bus_err=1;
//   step_req outside HALT ignored.
//  CPU_SSTEP_EN undefined: step_req unused; HALT exits only via halt_req=0.
// TESTING
//  reset_n 0->1, op1=0000, mem_ack=0 -> states 0,1,2,4; reg_we & pc_we in WB; instr_cnt=1 after 4 cycles.
//  op1=0110, cond=1 -> pc_we in EXEC with pc_sel=01; cond=0 -> pc_sel=00; reg_we never 1.
//  op1=1001, mem_ack high after 3 MEM cycles -> mem_req 3 cycles, mem_we=0, then WB wb_sel=01, reg_we=1.
//  op1=0101, mem_ack never -> mem_req/mem_we 15 cycles, bus_err=1, HALT, instr_cnt unchanged, halt stays.
//  halt_req=1 during EXEC of ALUR -> WB completes, HALT; halt_req=0 -> FETCH next cycle.
//  CPU_SSTEP_EN, halted, halt_req=1, step_req pulse -> one instruction, instr_cnt+1, back to HALT.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the datapath strobes.
// Optional single-step from HALT is enabled by defining CPU_SSTEP_EN.
module cpu_seq_ctrl #(
  parameter int unsigned OP_BIT_WIDTH = 4,
  parameter int unsigned WAIT_MAX     = 15,
  parameter int unsigned CNT_BITS     = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [OP_BIT_WIDTH-1:0] op1,
  input  logic                    cond,
  input  logic                    mem_ack,
  input  logic                    halt_req,
  input  logic                    step_req,
  output logic                    ir_we,
  output logic                    reg_we,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    pc_we,
  output logic [1:0]              pc_sel,
  output logic [1:0]              wb_sel,
  output logic [2:0]              state,
  output logic                    halted,
  output logic                    bus_err,
  output logic                    illegal,
  output logic [CNT_BITS-1:0]     instr_cnt
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [OP_BIT_WIDTH-1:0] OP_ALUR  = OP_BIT_WIDTH'(4'b0000);
  localparam logic [OP_BIT_WIDTH-1:0] OP_ALUI  = OP_BIT_WIDTH'(4'b1000);
  localparam logic [OP_BIT_WIDTH-1:0] OP_CMPR  = OP_BIT_WIDTH'(4'b0010);
  localparam logic [OP_BIT_WIDTH-1:0] OP_CMPI  = OP_BIT_WIDTH'(4'b1010);
  localparam logic [OP_BIT_WIDTH-1:0] OP_LW    = OP_BIT_WIDTH'(4'b1001);
  localparam logic [OP_BIT_WIDTH-1:0] OP_SW    = OP_BIT_WIDTH'(4'b0101);
  localparam logic [OP_BIT_WIDTH-1:0] OP_JAL   = OP_BIT_WIDTH'(4'b1011);
  localparam logic [OP_BIT_WIDTH-1:0] OP_BCOND = OP_BIT_WIDTH'(4'b0110);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                bus_err_q, bus_err_d;
  logic                step_run_q, step_run_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                step_rise;
  logic                boundary;

`ifdef CPU_SSTEP_EN
  logic step_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) step_prev_q <= 1'b0;
    else          step_prev_q <= step_req;
  end

  assign step_rise = step_req & ~step_prev_q;
`else
  logic unused_step;
  assign unused_step = step_req;
  assign step_rise   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      wait_q     <= '0;
      bus_err_q  <= 1'b0;
      step_run_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      bus_err_q  <= bus_err_d;
      step_run_q <= step_run_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next state and strobe decode from registered state plus current op1/cond/ack.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    bus_err_d  = bus_err_q;
    step_run_d = step_run_q;
    boundary   = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    wb_sel     = 2'b00;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // keep the IR strobe quiet while reset is held
        ir_we   = reset_n;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op1)
          OP_ALUR, OP_ALUI, OP_CMPR, OP_CMPI, OP_JAL: state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BCOND: begin
            pc_we    = 1'b1;
            pc_sel   = cond ? 2'b01 : 2'b00;
            boundary = 1'b1;
          end
          default: begin
            illegal  = 1'b1;
            pc_we    = 1'b1;
            boundary = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op1 == OP_SW);
        if (mem_ack) begin
          wait_d = '0;
          if (op1 == OP_SW) begin
            pc_we    = 1'b1;
            boundary = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (WAIT_W'(wait_q + WAIT_W'(1)) == WAIT_W'(WAIT_MAX)) begin
          // ack on the last allowed cycle is handled above and wins
          wait_d    = '0;
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = WAIT_W'(wait_q + WAIT_W'(1));
        end
      end
      S_WB: begin
        reg_we   = 1'b1;
        pc_we    = 1'b1;
        pc_sel   = (op1 == OP_JAL) ? 2'b10 : 2'b00;
        wb_sel   = (op1 == OP_JAL) ? 2'b10 : (op1 == OP_LW) ? 2'b01 : 2'b00;
        boundary = 1'b1;
      end
      S_HALT: begin
        if (!bus_err_q) begin
          if (step_rise) begin
            step_run_d = 1'b1;
            state_d    = S_FETCH;
          end else if (!halt_req) begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Instruction boundary: halt_req is only honoured here.
    if (boundary) begin
      state_d    = (halt_req || bus_err_q || step_run_q) ? S_HALT : S_FETCH;
      step_run_d = 1'b0;
    end
  end

  assign cnt_d     = pc_we ? CNT_BITS'(cnt_q + CNT_BITS'(1)) : cnt_q;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign bus_err   = bus_err_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: stimulus pushes expected retirements, a monitor checks each pc_we.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  op1;
  logic        cond, mem_ack, halt_req, step_req;
  logic        ir_we, reg_we, mem_req, mem_we, pc_we, halted, bus_err, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  cpu_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op1(op1), .cond(cond), .mem_ack(mem_ack),
    .halt_req(halt_req), .step_req(step_req), .ir_we(ir_we), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .wb_sel(wb_sel), .state(state), .halted(halted), .bus_err(bus_err),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op; logic cnd; int ack_at; logic hlt;
    logic [1:0] pc_sel; logic reg_we; logic [1:0] wb_sel;
    int lat; int memc; logic memwe; logic ill;
  } vec_t;

  typedef struct {
    logic [1:0] pc_sel; logic reg_we; logic [1:0] wb_sel;
    int lat; int memc; logic memwe; logic ill; int cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per pc_we and checks the retired instruction's profile.
  int cyc, memc;
  logic rw, mwe, ill, pend;
  logic [1:0] wbs;
  int pend_cnt;
  exp_t e;
  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 1'b0; cyc = 0; memc = 0; rw = 1'b0; mwe = 1'b0; ill = 1'b0; wbs = 2'b00;
    end else begin
      if (pend) begin
        check("instr_cnt", 64'(instr_cnt), 64'(pend_cnt));
        pend = 1'b0;
      end
      if (state == 3'd0) begin
        cyc = 1; memc = 0; rw = 1'b0; mwe = 1'b0; ill = 1'b0; wbs = 2'b00;
      end else begin
        cyc++;
      end
      if (mem_req) begin
        memc++;
        if (mem_we) mwe = 1'b1;
      end
      if (reg_we) begin
        rw = 1'b1; wbs = wb_sel;
      end
      if (illegal) ill = 1'b1;
      if (state == 3'd5)
        check("halt_quiet", 64'({ir_we, reg_we, mem_req, mem_we, pc_we, illegal}), 64'd0);
      if (pc_we) begin
        if (sb.size() == 0) begin
          check("unexpected_pc_we", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("pc_sel",  64'(pc_sel), 64'(e.pc_sel));
          check("reg_we",  64'(rw),     64'(e.reg_we));
          check("wb_sel",  64'(wbs),    64'(e.wb_sel));
          check("latency", 64'(cyc),    64'(e.lat));
          check("mem_cyc", 64'(memc),   64'(e.memc));
          check("mem_we",  64'(mwe),    64'(e.memwe));
          check("illegal", 64'(ill),    64'(e.ill));
          pend = 1'b1; pend_cnt = e.cnt;
        end
      end
    end
  end

  // Runs one instruction from FETCH until the next FETCH or HALT; returns MEM cycles seen.
  task automatic run_instr(input vec_t v, input logic push, output int k);
    int   n;
    exp_t x;
    k = 0;
    n = 0;
    while (state != 3'd0 && n < 50) begin step(); n++; end
    if (state != 3'd0) begin
      check("fetch_wait", 64'(state), 64'd0);
      return;
    end
    op1 = v.op; cond = v.cnd;
    if (push) begin
      exp_cnt++;
      x.pc_sel = v.pc_sel; x.reg_we = v.reg_we; x.wb_sel = v.wb_sel; x.lat = v.lat;
      x.memc = v.memc; x.memwe = v.memwe; x.ill = v.ill; x.cnt = exp_cnt;
      sb.push_back(x);
    end
    step();
    n = 0;
    while (state != 3'd0 && state != 3'd5 && n < 100) begin
      if (state == 3'd3) begin
        k++;
        mem_ack = (k == v.ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      if (state == 3'd2 && v.hlt) halt_req = 1'b1;
      step();
      n++;
    end
    mem_ack = 1'b0;
    if (n >= 100) check("instr_timeout", 64'(n), 64'd0);
  endtask

  // op cnd ack hlt | pc_sel reg_we wb_sel lat memc memwe ill
  vec_t vecs[] = '{
    '{4'b0000, 1'b0,  0, 1'b0, 2'b00, 1'b1, 2'b00,  4,  0, 1'b0, 1'b0},
    '{4'b0110, 1'b1,  0, 1'b0, 2'b01, 1'b0, 2'b00,  3,  0, 1'b0, 1'b0},
    '{4'b0110, 1'b0,  0, 1'b0, 2'b00, 1'b0, 2'b00,  3,  0, 1'b0, 1'b0},
    '{4'b1001, 1'b0,  3, 1'b0, 2'b00, 1'b1, 2'b01,  7,  3, 1'b0, 1'b0},
    '{4'b0101, 1'b0,  1, 1'b0, 2'b00, 1'b0, 2'b00,  4,  1, 1'b1, 1'b0},
    '{4'b1011, 1'b0,  0, 1'b0, 2'b10, 1'b1, 2'b10,  4,  0, 1'b0, 1'b0},
    '{4'b1010, 1'b1,  0, 1'b0, 2'b00, 1'b1, 2'b00,  4,  0, 1'b0, 1'b0},
    '{4'b1000, 1'b0,  0, 1'b0, 2'b00, 1'b1, 2'b00,  4,  0, 1'b0, 1'b0},
    '{4'b0010, 1'b0,  0, 1'b0, 2'b00, 1'b1, 2'b00,  4,  0, 1'b0, 1'b0},
    '{4'b1111, 1'b1,  0, 1'b0, 2'b00, 1'b0, 2'b00,  3,  0, 1'b0, 1'b1},
    '{4'b0011, 1'b0,  0, 1'b0, 2'b00, 1'b0, 2'b00,  3,  0, 1'b0, 1'b1},
    '{4'b0101, 1'b0, 15, 1'b0, 2'b00, 1'b0, 2'b00, 18, 15, 1'b1, 1'b0},
    '{4'b1001, 1'b0,  1, 1'b0, 2'b00, 1'b1, 2'b01,  5,  1, 1'b0, 1'b0},
    '{4'b0000, 1'b0,  0, 1'b1, 2'b00, 1'b1, 2'b00,  4,  0, 1'b0, 1'b0}
  };

  initial begin
    int   k;
    vec_t v;
    reset_n = 1'b0; op1 = 4'd0; cond = 1'b0; mem_ack = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state",   64'(state), 64'd0);
    check("rst_strobes", 64'({ir_we, reg_we, mem_req, mem_we, pc_we, illegal}), 64'd0);
    check("rst_sel",     64'({pc_sel, wb_sel}), 64'd0);
    check("rst_flags",   64'({halted, bus_err}), 64'd0);
    check("rst_cnt",     64'(instr_cnt), 64'd0);
    step();
    reset_n = 1'b1;

    foreach (vecs[i]) run_instr(vecs[i], 1'b1, k);

    // last vector raised halt_req during EXEC: WB completes, then HALT
    check("halt_state", 64'(state), 64'd5);
    check("halted",     64'(halted), 64'd1);
    repeat (3) step();
    check("halt_hold",  64'(state), 64'd5);
    halt_req = 1'b0;
    step();
    check("halt_exit",  64'(state), 64'd0);

    // SW with no ack: timeout, bus error, not retired
    v = '{4'b0101, 1'b0, 0, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0};
    run_instr(v, 1'b0, k);
    check("to_mem_cyc", 64'(k), 64'd15);
    check("to_state",   64'(state), 64'd5);
    check("to_bus_err", 64'(bus_err), 64'd1);
    check("to_cnt",     64'(instr_cnt), 64'(exp_cnt));
    repeat (4) step();
    check("to_stuck",   64'({state, halted, bus_err}), 64'({3'd5, 1'b1, 1'b1}));

    reset_n = 1'b0;
    step();
    exp_cnt = 0;
    check("rst2_flags", 64'({state, halted, bus_err}), 64'd0);
    check("rst2_cnt",   64'(instr_cnt), 64'd0);
    reset_n = 1'b1;

`ifdef CPU_SSTEP_EN
    halt_req = 1'b1;
    v = '{4'b0000, 1'b0, 0, 1'b0, 2'b00, 1'b1, 2'b00, 4, 0, 1'b0, 1'b0};
    run_instr(v, 1'b1, k);
    check("ss_halt", 64'(state), 64'd5);
    repeat (2) step();
    exp_cnt++;
    sb.push_back('{2'b00, 1'b1, 2'b00, 4, 0, 1'b0, 1'b0, exp_cnt});
    step_req = 1'b1;
    step();
    step_req = 1'b0;
    k = 0;
    step();
    while (state != 3'd5 && k < 20) begin step(); k++; end
    check("ss_back_halt", 64'(state), 64'd5);
    step();
    check("ss_cnt", 64'(instr_cnt), 64'(exp_cnt));
    halt_req = 1'b0;
`endif

    repeat (3) step();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
